alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Sequential command front-end for the team's 8-bit combinational ALU. It accepts operation commands over a valid/ready port, drives the ALU operand and select inputs from registers, and captures the ALU result and flags after a settle cycle. Tagged results are buffered in a small FIFO and returned over a second valid/ready port. It sits between a host or controller and the `alu` instance and replaces free-running stimulus with a handshaked, back-pressured issue path.

## Interface
- DEPTH, 4: result FIFO entries; power of two, ≥2.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on the same edge as cmd_valid=1.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_sel  in  3  ALU operation select.
- A  out  8  registered operand to ALU.
- B  out  8  registered operand to ALU.
- ALU_Sel  out  3  registered select to ALU.
- ALU_Out  in  8  ALU result (combinational from A/B/ALU_Sel).
- CarryOut  in  1  ALU carry flag.
- zeroFlag  in  1  ALU zero flag.
- res_valid  out  1  FIFO head valid (FIFO not empty).
- res_ready  in  1  pop FIFO head when res_valid=1.
- res_data  out  8  head result.
- res_carry  out  1  head carry.
- res_zero  out  1  head zero flag.
- res_err  out  1  head illegal-op flag.
- res_tag  out  4  head sequence tag.
- busy  out  1  state ≠ IDLE.
- count  out  log2(DEPTH)+1  FIFO occupancy.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE: cmd_ready = (count < DEPTH). On cmd_valid && cmd_ready, load A←cmd_a, B←cmd_b, ALU_Sel←cmd_sel, and latch the tag counter into the in-flight tag; go to ISSUE.
- ISSUE: settle cycle. A, B, and ALU_Sel are held. Go to CAPTURE.
- CAPTURE: push {ALU_Out, CarryOut, zeroFlag, err=0, tag} into the FIFO. Increment the tag counter (4-bit, 15→0 wrap). Go to IDLE.
- Illegal op: ALU_Sel = 3'b110. The command still traverses ISSUE and CAPTURE. The pushed entry is data=0, carry=0, zero=0, err=1. The tag is consumed normally.
- cmd_ready is 0 in ISSUE and CAPTURE. At most one command is in flight.
- A, B, and ALU_Sel hold their last issued values in IDLE and change only on acceptance.
- FIFO:
  - Circular, DEPTH entries, wrapping read and write pointers.
  - The head is presented combinationally from storage.
  - Pop occurs on res_valid && res_ready.
- Simultaneous push (CAPTURE) and pop: both occur; count is unchanged.
- Pop on empty is ignored.
- Push on full cannot occur, because acceptance requires count < DEPTH and count can only fall while a command is in flight.
- res_data, res_carry, res_zero, res_err, and res_tag are don't-care while res_valid=0; the bench must not check them.

## Timing
- Reset values: state IDLE, A=0, B=0, ALU_Sel=0, tag counter 0, FIFO empty, count=0, res_valid=0, busy=0. After reset, cmd_ready=1.
- Accept at edge E0:
  - A, B, and ALU_Sel are valid after E0.
  - busy=1 after E0.
  - Capture occurs at E2; res_valid=1 after E2 if the FIFO was empty.
  - cmd_ready can be 1 again after E2.
- Throughput: one command per 3 cycles. Latency from accept to result visible is 2 edges.
- Reset asserted in any state takes effect at the next edge:
  - Any in-flight command is discarded without a push.
  - The FIFO is flushed.
  - The tag counter returns to 0.
- Input sampling: cmd_* are sampled only on the accepting edge. res_ready is sampled every edge.

## Test plan
- Bench uses a behavioral ALU model with these operations:
  - 000: {CarryOut, ALU_Out} = A+B.
  - 001: ALU_Out = A−B, CarryOut = borrow.
  - zeroFlag = (ALU_Out == 0).
- Reset: hold reset 2 cycles → every output at its reset value, cmd_ready=1.
- Single add: A=8'h04, B=8'h02, sel=000 accepted at E0 → A=4, B=2, ALU_Sel=0 after E0; busy=1 after E0; res_valid=1 after E2 with data=6, carry=0, zero=0, err=0, tag=0.
- Flags:
  - 8'hFF+8'h01 → data=0, carry=1, zero=1.
  - 8'h02−8'h02 (sel=001) → data=0, zero=1, tag=1.
- Backpressure: res_ready=0, issue 5 commands with DEPTH=4 → count reaches 4, cmd_ready stays 0 and the 5th command stalls; one pop → 5th accepted, count returns to 4 after its capture; drain → tags 0..4 come out in order.
- Illegal op and tag wrap:
  - sel=110 → err=1, data=0.
  - 17 commands drained continuously → tags 0..15 then 0.
  - A capture coinciding with a pop leaves count unchanged.
- Reset mid-op: assert reset in CAPTURE with 2 entries queued → after the edge, res_valid=0, count=0, busy=0; the next result has tag=0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Handshaked command front-end for the 8-bit combinational ALU: registers operands,
// waits one settle cycle, captures result/flags with a sequence tag into a small result FIFO.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    input  logic [2:0]               cmd_sel,
    output logic [7:0]               A,
    output logic [7:0]               B,
    output logic [2:0]               ALU_Sel,
    input  logic [7:0]               ALU_Out,
    input  logic                     CarryOut,
    input  logic                     zeroFlag,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_data,
    output logic                     res_carry,
    output logic                     res_zero,
    output logic                     res_err,
    output logic [3:0]               res_tag,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [2:0]    SEL_ILLEGAL = 3'b110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // FIFO word layout: {data[14:7], carry[6], zero[5], err[4], tag[3:0]}
    typedef logic [14:0] entry_t;

    state_t          state_q, state_d;
    logic [7:0]      a_q, a_d;
    logic [7:0]      b_q, b_d;
    logic [2:0]      sel_q, sel_d;
    logic [3:0]      tag_q, tag_d;
    logic [3:0]      flight_tag_q, flight_tag_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    entry_t          mem_q [DEPTH];
    entry_t          push_word;
    entry_t          head_word;
    logic            push;
    logic            pop;
    logic            ready_c;

    // Next-state and issue control
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        tag_d        = tag_q;
        flight_tag_d = flight_tag_q;
        push         = 1'b0;
        ready_c      = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = (count_q < DEPTH_C);
                if (cmd_valid && ready_c) begin
                    a_d          = cmd_a;
                    b_d          = cmd_b;
                    sel_d        = cmd_sel;
                    flight_tag_d = tag_q;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                push    = 1'b1;
                tag_d   = tag_q + 4'd1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Illegal selects are masked here so whatever the ALU drives for them never escapes.
    always_comb begin
        push_word = {ALU_Out, CarryOut, zeroFlag, 1'b0, flight_tag_q};
        if (sel_q == SEL_ILLEGAL) begin
            push_word = {8'h00, 1'b0, 1'b0, 1'b1, flight_tag_q};
        end
    end

    assign pop = (count_q != '0) && res_ready;

    // Full can never coincide with a push, since acceptance already required room.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            tag_q        <= '0;
            flight_tag_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            tag_q        <= tag_d;
            flight_tag_q <= flight_tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign head_word = mem_q[rd_ptr_q];

    assign cmd_ready = ready_c;
    assign A         = a_q;
    assign B         = b_q;
    assign ALU_Sel   = sel_q;
    assign res_valid = (count_q != '0);
    assign res_data  = head_word[14:7];
    assign res_carry = head_word[6];
    assign res_zero  = head_word[5];
    assign res_err   = head_word[4];
    assign res_tag   = head_word[3:0];
    assign busy      = (state_q != IDLE);
    assign count     = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU, queue-based result model, one task per scenario.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_a = '0;
    logic [7:0]    cmd_b = '0;
    logic [2:0]    cmd_sel = '0;
    logic [7:0]    A, B;
    logic [2:0]    ALU_Sel;
    logic [7:0]    ALU_Out;
    logic          CarryOut, zeroFlag;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [7:0]    res_data;
    logic          res_carry, res_zero, res_err;
    logic [3:0]    res_tag;
    logic          busy;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       carry;
        logic       zero;
        logic       err;
        logic [3:0] tag;
    } res_t;

    res_t exp_q[$];
    int   tag_exp = 0;

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .A(A), .B(B), .ALU_Sel(ALU_Sel),
        .ALU_Out(ALU_Out), .CarryOut(CarryOut), .zeroFlag(zeroFlag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero),
        .res_err(res_err), .res_tag(res_tag),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; the illegal select drives junk that the sequencer must mask.
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide = 9'd0;
        case (ALU_Sel)
            3'b000: alu_wide = {1'b0, A} + {1'b0, B};
            3'b001: alu_wide = {1'b0, A} - {1'b0, B};
            3'b010: alu_wide = {1'b0, A & B};
            3'b011: alu_wide = {1'b0, A | B};
            3'b100: alu_wide = {1'b0, A ^ B};
            3'b101: alu_wide = {1'b0, ~A};
            3'b110: alu_wide = 9'h1A5;
            default: alu_wide = {A, 1'b0};
        endcase
    end
    assign ALU_Out  = alu_wide[7:0];
    assign CarryOut = alu_wide[8];
    assign zeroFlag = (alu_wide[7:0] == 8'd0);

    function automatic res_t ref_res(input int a, input int b, input int sel, input int tag);
        res_t r;
        int   v;
        bit   c;
        v = 0;
        c = 1'b0;
        case (sel)
            0: begin v = a + b; c = (v > 255); v = v % 256; end
            1: begin v = a - b; c = (a < b); if (v < 0) v = v + 256; end
            2: v = a & b;
            3: v = a | b;
            4: v = a ^ b;
            5: v = 255 - a;
            7: begin v = (a * 2) % 256; c = (a >= 128); end
            default: v = 0;
        endcase
        r.data  = v[7:0];
        r.carry = c;
        r.zero  = (v == 0);
        r.err   = 1'b0;
        r.tag   = tag[3:0];
        if (sel == 6) begin
            r.data  = 8'h00;
            r.carry = 1'b0;
            r.zero  = 1'b0;
            r.err   = 1'b1;
        end
        return r;
    endfunction

    function automatic res_t head();
        return {res_data, res_carry, res_zero, res_err, res_tag};
    endfunction

    task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
        exp_q.push_back(ref_res(a, b, sel, tag_exp));
        tag_exp = (tag_exp + 1) % 16;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        tag_exp = 0;
    endtask

    // Drives one command until accepted; returns 1 ns after the accepting edge.
    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
        bit ok;
        ok = 1'b0;
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b required=1 within 64 cycles", cmd_ready);
        end else begin
            @(posedge clk);
            #1 model_accept(a, b, sel);
        end
        cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for res_valid; returns at a negedge.
    task automatic wait_res();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL res_valid_timeout: res_valid=%b required=1 within 32 cycles", res_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        tag_exp = 0;
        @(negedge clk);
        checks++;
        if ({A, B, ALU_Sel, res_valid, busy, count, cmd_ready} !== {8'd0, 8'd0, 3'd0, 1'b0, 1'b0, CW'(0), 1'b1}) begin
            errors++;
            $display("FAIL reset_state: A=%h B=%h sel=%h rv=%b busy=%b count=%0d rdy=%b required 0/0/0/0/0/0/1",
                     A, B, ALU_Sel, res_valid, busy, count, cmd_ready);
        end
        $display("test_reset: done");
    endtask

    task automatic test_single_add();
        res_t e;
        apply_reset();
        cmd_a = 8'h04; cmd_b = 8'h02; cmd_sel = 3'b000; cmd_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL add_ready: cmd_ready=%b required=1", cmd_ready); end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        model_accept(8'h04, 8'h02, 3'b000);
        @(negedge clk);
        checks++;
        if ({A, B, ALU_Sel, busy, cmd_ready, res_valid} !== {8'h04, 8'h02, 3'b000, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_after_e0: A=%h B=%h sel=%h busy=%b rdy=%b rv=%b required 04/02/0/1/0/0",
                     A, B, ALU_Sel, busy, cmd_ready, res_valid);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL add_after_e1: res_valid=%b required=0", res_valid); end
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (res_valid !== 1'b1 || head() !== e || e !== {8'd6, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL add_result: rv=%b head=%h required rv=1 head=%h", res_valid, head(), e);
        end
        checks++;
        if ({busy, count, cmd_ready} !== {1'b0, CW'(1), 1'b1}) begin
            errors++;
            $display("FAIL add_after_e2: busy=%b count=%0d rdy=%b required 0/1/1", busy, count, cmd_ready);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({res_valid, count} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL add_pop: rv=%b count=%0d required 0/0", res_valid, count);
        end
        $display("test_single_add: done");
    endtask

    task automatic test_flags();
        res_t e;
        apply_reset();
        res_ready = 1'b1;
        send_cmd(8'hFF, 8'h01, 3'b000);
        wait_res();
        e = exp_q.pop_front();
        checks++;
        if (head() !== e || {res_data, res_carry, res_zero} !== {8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL flags_add_carry: head=%h required=%h", head(), e);
        end
        send_cmd(8'h02, 8'h02, 3'b001);
        wait_res();
        e = exp_q.pop_front();
        checks++;
        if (head() !== e || {res_data, res_zero, res_tag} !== {8'h00, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL flags_sub_zero: head=%h required=%h", head(), e);
        end
        @(posedge clk);
        #1 res_ready = 1'b0;
        $display("test_flags: done");
    endtask

    task automatic test_backpressure();
        res_t e;
        logic [7:0] a5, b5;
        logic [2:0] s5;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            send_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({count, cmd_ready, busy} !== {CW'(4), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL bp_full: count=%0d rdy=%b busy=%b required 4/0/0", count, cmd_ready, busy);
        end
        a5 = 8'($urandom); b5 = 8'($urandom); s5 = 3'($urandom_range(0, 5));
        cmd_a = a5; cmd_b = b5; cmd_sel = s5; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({cmd_ready, busy} !== 2'b00) begin
                errors++;
                $display("FAIL bp_stall: cycle=%0d rdy=%b busy=%b required 0/0", i, cmd_ready, busy);
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (res_valid !== 1'b1 || head() !== e) begin
            errors++;
            $display("FAIL bp_first_pop: rv=%b head=%h required 1/%h", res_valid, head(), e);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, count} !== {1'b1, CW'(3)}) begin
            errors++;
            $display("FAIL bp_room: rdy=%b count=%0d required 1/3", cmd_ready, count);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        model_accept(a5, b5, s5);
        repeat (3) @(negedge clk);
        checks++;
        if (count !== CW'(4)) begin errors++; $display("FAIL bp_refill: count=%0d required 4", count); end
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (res_valid !== 1'b1 || head() !== e || res_tag !== 4'(i + 1)) begin
                errors++;
                $display("FAIL bp_drain: idx=%0d rv=%b head=%h required 1/%h", i, res_valid, head(), e);
            end
            res_ready = 1'b1;
            @(posedge clk);
            #1 res_ready = 1'b0;
        end
        $display("test_backpressure: done");
    endtask

    task automatic test_illegal_and_wrap();
        res_t e;
        logic [2:0] s;
        apply_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            s = (i % 5 == 2) ? 3'b110 : 3'($urandom_range(0, 7));
            send_cmd(8'($urandom), 8'($urandom), s);
            wait_res();
            e = exp_q.pop_front();
            checks++;
            if (head() !== e || res_tag !== 4'(i % 16)) begin
                errors++;
                $display("FAIL wrap_result: idx=%0d sel=%0d head=%h required=%h", i, s, head(), e);
            end
            if (s == 3'b110) begin
                checks++;
                if ({res_err, res_data} !== {1'b1, 8'h00}) begin
                    errors++;
                    $display("FAIL illegal_op: err=%b data=%h required 1/00", res_err, res_data);
                end
            end
        end
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== CW'(0)) begin errors++; $display("FAIL wrap_empty: count=%0d required 0", count); end
        $display("test_illegal_and_wrap: done");
    endtask

    task automatic test_back_to_back();
        res_t e;
        apply_reset();
        send_cmd(8'($urandom), 8'($urandom), 3'b000);
        repeat (3) @(negedge clk);
        send_cmd(8'($urandom), 8'($urandom), 3'b001);
        @(negedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (res_valid !== 1'b1 || head() !== e || count !== CW'(1)) begin
            errors++;
            $display("FAIL b2b_first: rv=%b head=%h count=%0d required 1/%h/1", res_valid, head(), count, e);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (count !== CW'(1) || res_valid !== 1'b1 || head() !== e) begin
            errors++;
            $display("FAIL push_pop_same_edge: count=%0d head=%h required 1/%h", count, head(), e);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        $display("test_back_to_back: done");
    endtask

    task automatic test_random();
        int got;
        res_t e;
        apply_reset();
        got = 0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    send_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
                end
            end
            begin
                for (int cyc = 0; cyc < 2000 && got < 24; cyc++) begin
                    @(negedge clk);
                    res_ready = 1'($urandom_range(0, 1));
                    if (count > CW'(DEPTH)) begin
                        checks++;
                        errors++;
                        $display("FAIL rand_count: count=%0d required <= %0d", count, DEPTH);
                    end
                    if (res_valid === 1'b1 && res_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rand_spurious: head=%h required no result", head());
                        end else begin
                            e = exp_q.pop_front();
                            if (head() !== e) begin
                                errors++;
                                $display("FAIL rand_result: idx=%0d head=%h required=%h", got, head(), e);
                            end
                        end
                        got++;
                    end
                end
                @(posedge clk);
                #1 res_ready = 1'b0;
            end
        join
        checks++;
        if (got != 24) begin errors++; $display("FAIL rand_count_results: got=%0d required=24", got); end
        $display("test_random: done");
    endtask

    task automatic test_reset_midop();
        res_t e;
        apply_reset();
        send_cmd(8'($urandom), 8'($urandom), 3'b000);
        send_cmd(8'($urandom), 8'($urandom), 3'b000);
        repeat (3) @(negedge clk);
        send_cmd(8'($urandom), 8'($urandom), 3'b001);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        tag_exp = 0;
        @(negedge clk);
        checks++;
        if ({res_valid, count, busy, cmd_ready} !== {1'b0, CW'(0), 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midop_reset: rv=%b count=%0d busy=%b rdy=%b required 0/0/0/1",
                     res_valid, count, busy, cmd_ready);
        end
        send_cmd(8'h10, 8'h20, 3'b000);
        wait_res();
        e = exp_q.pop_front();
        checks++;
        if (head() !== e || res_tag !== 4'd0 || count !== CW'(1)) begin
            errors++;
            $display("FAIL midop_next_tag: head=%h count=%0d required %h/1", head(), count, e);
        end
        $display("test_reset_midop: done");
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_flags();
        test_backpressure();
        test_illegal_and_wrap();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
